// File: rtl/gsim_matvec.sv
// b = A*x for the fixed 16x16 banded GSIM matrix, one 7-tap MAC row at a time.
// Optional saturation of the rounded result is enabled by defining GSIM_MV_SAT_EN.
module gsim_matvec (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_en,
  input  logic [31:0] x_in,
  output logic        ready,
  output logic        out_valid,
  output logic [15:0] b_out
);

  typedef enum logic {LOAD, CALC} state_e;

  state_e             state_q, state_d;
  logic [3:0]         k_q, k_d;
  logic [3:0]         i_q, i_d;
  logic [2:0]         c_q, c_d;
  logic signed [39:0] acc_q, acc_d;
  logic               out_valid_q, out_valid_d;
  logic [15:0]        b_out_q, b_out_d;
  logic [31:0]        x_q [16];
  logic [31:0]        x_d [16];

  logic signed [5:0]  j;
  logic signed [5:0]  coef;
  logic [31:0]        x_sel;
  logic signed [39:0] prod;
`ifdef GSIM_MV_SAT_EN
  logic signed [23:0] rnd;
`endif

  // Tap c of row i reads column j = i-3+c; columns outside 0..15 read as zero.
  always_comb begin
    j = $signed({2'b00, i_q}) - 6'sd3 + $signed({3'b000, c_q});
    case (c_q)
      3'd0, 3'd6: coef = -6'sd1;
      3'd1, 3'd5: coef = 6'sd6;
      3'd2, 3'd4: coef = -6'sd13;
      default:    coef = 6'sd20;
    endcase
    x_sel = (j[5:4] == 2'b00) ? x_q[j[3:0]] : 32'd0;
    prod  = $signed({{8{x_sel[31]}}, x_sel}) * 40'(coef);
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    i_d         = i_q;
    c_d         = c_q;
    acc_d       = acc_q;
    out_valid_d = 1'b0;
    b_out_d     = b_out_q;
    x_d         = x_q;
`ifdef GSIM_MV_SAT_EN
    rnd         = '0;
`endif
    case (state_q)
      LOAD: begin
        if (in_en) begin
          x_d[k_q] = x_in;
          k_d      = k_q + 4'd1;
          if (k_q == 4'd15) begin
            state_d = CALC;
            i_d     = 4'd0;
            c_d     = 3'd0;
            acc_d   = '0;
          end
        end
      end
      CALC: begin
        // The first tap of each row starts from zero instead of the old sum.
        acc_d = ((c_q == 3'd0) ? 40'sd0 : acc_q) + prod;
        c_d   = c_q + 3'd1;
        if (c_q == 3'd6) begin
          c_d         = 3'd0;
          out_valid_d = 1'b1;
`ifdef GSIM_MV_SAT_EN
          rnd = 24'((acc_d + 40'sh8000) >>> 16);
          if (rnd > 24'sd32767)       b_out_d = 16'h7FFF;
          else if (rnd < -24'sd32768) b_out_d = 16'h8000;
          else                        b_out_d = rnd[15:0];
`else
          b_out_d = 16'((acc_d + 40'sh8000) >>> 16);
`endif
          i_d = i_q + 4'd1;
          if (i_q == 4'd15) begin
            state_d = LOAD;
            k_d     = 4'd0;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= LOAD;
      k_q         <= 4'd0;
      i_q         <= 4'd0;
      c_q         <= 3'd0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      b_out_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      i_q         <= i_d;
      c_q         <= c_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      b_out_q     <= b_out_d;
    end
  end

  // Stored frame data needs no reset; an interrupted frame is simply reloaded.
  always_ff @(posedge clk) begin
    x_q <= x_d;
  end

  assign ready     = (state_q == LOAD);
  assign out_valid = out_valid_q;
  assign b_out     = b_out_q;

endmodule

// File: tb/tb_gsim_matvec.sv
// Bench for gsim_matvec: directed frame table, gap/noise, reset-abort and random frames
// checked cycle by cycle against a matrix-level reference model.
module tb_gsim_matvec;

  logic        clk;
  logic        reset;
  logic        in_en;
  logic [31:0] x_in;
  logic        ready;
  logic        out_valid;
  logic [15:0] b_out;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [15:0][31:0] x;
    logic [15:0][15:0] exp;
  } vec_t;

  vec_t        tbl [4];
  logic [15:0] got [16];
  int e27 [16] = '{20, -13, 6, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int e28 [16] = '{12, -1, 5, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 5, -1, 12};
  int e29 [16] = '{10, -6, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  gsim_matvec dut (
    .clk       (clk),
    .reset     (reset),
    .in_en     (in_en),
    .x_in      (x_in),
    .ready     (ready),
    .out_valid (out_valid),
    .b_out     (b_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: b_i = round_half_up(sum_j A[i][j]*x[j] / 2^16), then wrap or saturate.
  function automatic logic [15:0] model_row(input logic [15:0][31:0] xv, input int i);
    longint s = 0;
    longint r;
    int d;
    int a;
    for (int jj = 0; jj < 16; jj++) begin
      d = (i > jj) ? i - jj : jj - i;
      case (d)
        0:       a = 20;
        1:       a = -13;
        2:       a = 6;
        3:       a = -1;
        default: a = 0;
      endcase
      s += longint'(a) * longint'($signed(xv[jj]));
    end
    r = (s + 32768) >>> 16;
`ifdef GSIM_MV_SAT_EN
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`endif
    return r[15:0];
  endfunction

  function automatic logic [15:0][15:0] model_frame(input logic [15:0][31:0] xv);
    logic [15:0][15:0] e;
    for (int i = 0; i < 16; i++) e[i] = model_row(xv, i);
    return e;
  endfunction

  // Entered and left at #1 after a rising edge. stop_at>0 abandons the frame after
  // that many CALC edges, leaving the DUT mid-frame.
  task automatic run_frame(input logic [15:0][31:0] xv, input logic [15:0][15:0] exp,
                           input bit gaps, input bit noise, input int stop_at);
    logic [15:0] last;
    for (int k = 0; k < 16; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_en = 1'b0;
          x_in  = $urandom;
          @(posedge clk); #1;
        end
      end
      chk("ready_load", 32'(ready), 32'd1);
      in_en = 1'b1;
      x_in  = xv[k];
      @(posedge clk); #1;
    end
    last = b_out;
    for (int n = 1; n <= 112; n++) begin
      if (stop_at > 0 && n > stop_at) break;
      in_en = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise && n == 112) in_en = 1'b1;
      x_in = $urandom;
      @(posedge clk); #1;
      chk("ready_calc", 32'(ready), (n == 112) ? 32'd1 : 32'd0);
      chk("out_valid", 32'(out_valid), (n % 7 == 0) ? 32'd1 : 32'd0);
      if (n % 7 == 0) begin
        chk($sformatf("b_out_row%0d", n / 7 - 1), 32'(b_out), 32'(exp[n / 7 - 1]));
        got[n / 7 - 1] = b_out;
        last = b_out;
      end else begin
        chk("b_out_hold", 32'(b_out), 32'(last));
      end
    end
    if (stop_at == 0) begin
      in_en = 1'b0;
      @(posedge clk); #1;
      chk("post_frame_valid", 32'(out_valid), 32'd0);
      chk("post_frame_ready", 32'(ready), 32'd1);
    end
  endtask

  initial begin
    logic [15:0][31:0] xv;
    logic [15:0][31:0] ones;

    reset = 1'b0;
    in_en = 1'b0;
    x_in  = '0;
    for (int i = 0; i < 16; i++) ones[i] = 32'h0001_0000;

    tbl[0].x = '0;
    tbl[0].exp = '0;
    tbl[1].x = '0;
    tbl[1].x[0] = 32'h0001_0000;
    tbl[2].x = ones;
    tbl[3].x = '0;
    tbl[3].x[0] = 32'h0000_8000;
    for (int r = 0; r < 16; r++) begin
      tbl[1].exp[r] = 16'(e27[r]);
      tbl[2].exp[r] = 16'(e28[r]);
      tbl[3].exp[r] = 16'(e29[r]);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_b_out", 32'(b_out), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 4; t++) run_frame(tbl[t].x, tbl[t].exp, 1'b0, 1'b0, 0);

    for (int i = 0; i < 16; i++) xv[i] = 32'h7FFF_0000;
    run_frame(xv, model_frame(xv), 1'b0, 1'b0, 0);
`ifdef GSIM_MV_SAT_EN
    chk("big_row3", 32'(got[3]), 32'h7FFF);
`else
    chk("big_row3", 32'(got[3]), 32'hFFFC);
`endif

    run_frame(ones, tbl[2].exp, 1'b1, 1'b1, 0);
    run_frame(ones, tbl[2].exp, 1'b0, 1'b0, 0);

    // Abort during CALC while row 5's pulse is on the output.
    run_frame(ones, tbl[2].exp, 1'b0, 1'b0, 42);
    chk("pre_abort_valid", 32'(out_valid), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_b_out", 32'(b_out), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    run_frame(tbl[1].x, tbl[1].exp, 1'b0, 1'b0, 0);

    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 16; i++) begin
        xv[i] = (f < 3) ? 32'($signed($urandom_range(0, 32'h000F_FFFF)) - 32'sh0008_0000)
                        : $urandom;
      end
      run_frame(xv, model_frame(xv), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gsim_matvec.md
GSIM_MATVEC -- requirements
Module: gsim_matvec

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port in_en, input, 1 bit: x_in is valid this cycle.
REQ-004 SHALL have port x_in, input, 32 bits: solution element, signed Q16.16 two's complement.
REQ-005 SHALL have port ready, output, 1 bit: block is accepting x_in.
REQ-006 SHALL have port out_valid, output, 1 bit: b_out is valid this cycle.
REQ-007 SHALL have port b_out, output, 16 bits: reconstructed right-hand side, signed integer.

Function
REQ-008 SHALL compute b = A*x for the fixed 16x16 banded matrix of the GSIM solver: A[i][i]=20, A[i][i±1]=-13, A[i][i±2]=6, A[i][i±3]=-1, all other entries 0.
REQ-009 SHALL have states LOAD and CALC; the state after reset is LOAD.
REQ-010 In LOAD, SHALL drive ready=1 and store x_in into x[k] on each edge with in_en=1; k starts at 0 and increments once per stored element.
REQ-011 in_en=0 cycles in LOAD SHALL be gaps: nothing is stored and k holds.
REQ-012 On the edge storing x[15] (edge E), SHALL enter CALC with row i=0 and ready=0.
REQ-013 In CALC, in_en and x_in SHALL be ignored.
REQ-014 CALC SHALL spend exactly 7 MAC cycles per row, visiting j=i-3..i+3 in order; each j outside 0..15 SHALL contribute zero.
REQ-015 The accumulator SHALL be signed and at least 40 bits wide, and SHALL clear at the start of each row.
REQ-016 The result for row i SHALL be formed as (acc + 0x8000) arithmetically shifted right by 16 (round half up), then reduced to 16 bits per REQ-024/REQ-025.
REQ-017 out_valid SHALL be 1 for exactly one cycle per row, following edge E+7*(i+1), with b_out valid in that same cycle.
REQ-018 Rows SHALL be output in order 0..15.
REQ-019 Outside valid cycles, b_out SHALL hold its last value.
REQ-020 After the row-15 output edge (E+112), SHALL return to LOAD with k=0 and ready=1 in the next cycle.
REQ-021 An in_en on that same edge (E+112) SHALL be ignored.

Reset
REQ-022 When reset=0, SHALL immediately force state=LOAD, k=0, i=0, acc=0, ready=1, out_valid=0 and b_out=0; this holds even mid-LOAD or mid-CALC.
REQ-023 A frame interrupted by reset SHALL be discarded; stored x[] contents need not be cleared.

Configuration
REQ-024 With GSIM_MV_SAT_EN defined, the rounded result SHALL saturate to the range -32768..32767.
REQ-025 Without GSIM_MV_SAT_EN, b_out SHALL be the low 16 bits of the rounded result (wrap-around).

Verification
REQ-026 All 16 x_in=0x00000000 -> 16 out_valid pulses, each with b_out=0; first pulse at E+7, last at E+112.
REQ-027 x[0]=0x00010000, all others 0 -> b_out = 20, -13, 6, -1, then 0 x12.
REQ-028 All x=0x00010000 -> b_out = 12, -1, 5, 4 (x10), 5, -1, 12.
REQ-029 x[0]=0x00008000, others 0 -> b_out = 10, -6, 3, 0, then 0 x12 (round half up).
REQ-030 All x=0x7FFF0000 -> row 3 b_out = 0x7FFF with GSIM_MV_SAT_EN, 0xFFFC without it.
REQ-031 reset=0 asserted during CALC after row 5's output -> out_valid drops at once; after release, ready=1 and a fresh 16-element frame reproduces REQ-027 exactly.
REQ-032 in_en gaps during LOAD and in_en=1 during CALC -> results identical to the REQ-028 gap-free frame.
